// File: rtl/sample_rate_crusher.sv
// sample_rate_crusher: zero-order-hold sample-rate reduction followed by a
// wet/dry blend against the undecimated input. One sample in per start pulse,
// one sample out per done pulse, fixed 3-clock latency in both bypass and
// active modes.
module sample_rate_crusher #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic [2:0]       hold_factor,
  input  logic [2:0]       mix_amount,
  input  logic [WIDTH-1:0] incoming_sample,
  output logic [WIDTH-1:0] modified_sample,
  output logic             done
);

  // Sum width: |held*w + sample*(8-w)| <= 2^(WIDTH-1) * 8, so 4 guard bits.
  localparam int SW = WIDTH + 4;
  localparam logic signed [SW-1:0] EIGHT = SW'(8);

  typedef enum logic [1:0] {IDLE, HOLD, MIX, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] cap_sample;
  logic             cap_en;
  logic [2:0]       cap_hf;
  logic [2:0]       cap_mix;
  logic [WIDTH-1:0] held;
  logic [2:0]       cnt;
  logic [3:0]       lat_w;     // wet weight for the current hold period, 1..8
  logic             bypass;
  logic [WIDTH-1:0] result;

  logic signed [SW-1:0] held_x, samp_x, wet_w, dry_w, sum, shifted;

  // Blend arithmetic: sign-extend both operands, weight, floor-divide by 8.
  always_comb begin
    held_x  = {{(SW-WIDTH){held[WIDTH-1]}}, held};
    samp_x  = {{(SW-WIDTH){cap_sample[WIDTH-1]}}, cap_sample};
    wet_w   = {{(SW-4){1'b0}}, lat_w};
    dry_w   = EIGHT - wet_w;
    sum     = held_x * wet_w + samp_x * dry_w;
    shifted = sum >>> 3;
  end

  // Control FSM plus datapath registers; done and modified_sample are registered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      cap_sample      <= '0;
      cap_en          <= 1'b0;
      cap_hf          <= '0;
      cap_mix         <= '0;
      held            <= '0;
      cnt             <= '0;
      lat_w           <= 4'd8;
      bypass          <= 1'b1;
      result          <= '0;
      modified_sample <= '0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cap_sample <= incoming_sample;
            cap_en     <= enable;
            cap_hf     <= hold_factor;
            cap_mix    <= mix_amount;
            state      <= HOLD;
          end
        end
        HOLD: begin
          bypass <= !cap_en;
          if (!cap_en) begin
            // Parking the counter at 0 forces a refresh on the first enabled sample.
            cnt <= '0;
          end else if (cnt == 3'd0) begin
            // Hold period boundary: the only point where N and w are re-latched.
            held  <= cap_sample;
            cnt   <= cap_hf;
            lat_w <= {1'b0, cap_mix} + 4'd1;
          end else begin
            cnt <= cnt - 3'd1;
          end
          state <= MIX;
        end
        MIX: begin
          result <= bypass ? cap_sample : shifted[WIDTH-1:0];
          state  <= DONE;
        end
        DONE: begin
          modified_sample <= result;
          done            <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_rate_crusher.sv
// Directed bench for sample_rate_crusher: reset, bypass latency, hold,
// mix, floor rounding, extremes, busy drop and mid-operation abort.
module tb_sample_rate_crusher;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  hold_factor = '0;
  logic [2:0]  mix_amount = '0;
  logic [11:0] incoming_sample = '0;
  logic [11:0] modified_sample;
  logic        done;

  int vecs = 0;
  int errs = 0;

  sample_rate_crusher #(.WIDTH(12)) dut (
    .clock(clock), .reset(reset), .start(start), .enable(enable),
    .hold_factor(hold_factor), .mix_amount(mix_amount),
    .incoming_sample(incoming_sample), .modified_sample(modified_sample),
    .done(done)
  );

  always #5 clock = ~clock;

  // One sample, then watch 63 clocks: first done cycle, done count, output.
  task automatic run_sample(input logic en, input logic [2:0] hf, input logic [2:0] mx,
                            input int smp, output int res, output int lat, output int nd);
    enable = en; hold_factor = hf; mix_amount = mx; incoming_sample = 12'(smp);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = -1; nd = 0; res = 9999;
    for (int k = 1; k < 64; k++) begin
      @(posedge clock); #1;
      if (done) begin
        nd++;
        if (lat < 0) begin lat = k; res = $signed(modified_sample); end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    int bad_done, bad_out;
    bad_done = 0; bad_out = 0;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      start = (k % 2 == 0); incoming_sample = 12'd55; enable = 1'b1;
      @(posedge clock); #1;
      if (done) bad_done++;
      if (modified_sample != 12'd0) bad_out++;
    end
    start = 1'b0;
    vecs++; if (bad_done !== 0) begin errs++; $display("FAIL reset_done: %0d cycles high, required 0", bad_done); end
    vecs++; if (bad_out !== 0) begin errs++; $display("FAIL reset_out: %0d cycles nonzero, required 0", bad_out); end
    reset = 1'b1;
    bad_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      if (done) bad_done++;
    end
    vecs++; if (bad_done !== 0) begin errs++; $display("FAIL idle_done: %0d cycles high, required 0", bad_done); end
  endtask

  task automatic test_bypass();
    int r, l, n;
    do_reset();
    run_sample(1'b0, 3'd0, 3'd0, -100, r, l, n);
    vecs++; if (r !== -100) begin errs++; $display("FAIL bypass_out: got %0d required -100", r); end
    vecs++; if (l !== 3) begin errs++; $display("FAIL bypass_latency: got %0d required 3", l); end
    vecs++; if (n !== 1) begin errs++; $display("FAIL bypass_ndone: got %0d required 1", n); end
  endtask

  task automatic test_hold();
    int ins[5]  = '{10, 20, 30, 40, 50};
    int exps[5] = '{10, 10, 10, 10, 50};
    // mix changes mid-period must not affect outputs until the refresh
    logic [2:0] mxs[5] = '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0};
    int r, l, n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_sample(1'b1, 3'd3, mxs[i], ins[i], r, l, n);
      vecs++; if (r !== exps[i] || l !== 3 || n !== 1)
        begin errs++; $display("FAIL hold[%0d]: got %0d lat %0d n %0d required %0d lat 3 n 1", i, r, l, n, exps[i]); end
    end
  endtask

  task automatic test_mix();
    int r, l, n;
    do_reset();
    run_sample(1'b1, 3'd1, 3'd3, 100, r, l, n);
    vecs++; if (r !== 100) begin errs++; $display("FAIL mix0: got %0d required 100", r); end
    run_sample(1'b1, 3'd1, 3'd3, 200, r, l, n);
    vecs++; if (r !== 150) begin errs++; $display("FAIL mix1: got %0d required 150", r); end
  endtask

  task automatic test_floor_extremes();
    int r, l, n;
    do_reset();
    run_sample(1'b1, 3'd1, 3'd0, 3, r, l, n);
    vecs++; if (r !== 3) begin errs++; $display("FAIL floor0: got %0d required 3", r); end
    run_sample(1'b1, 3'd1, 3'd0, -4, r, l, n);
    vecs++; if (r !== -4) begin errs++; $display("FAIL floor1: got %0d required -4", r); end
    run_sample(1'b1, 3'd0, 3'd0, -2048, r, l, n);
    vecs++; if (r !== -2048) begin errs++; $display("FAIL min_extreme: got %0d required -2048", r); end
    run_sample(1'b1, 3'd0, 3'd0, 2047, r, l, n);
    vecs++; if (r !== 2047) begin errs++; $display("FAIL max_extreme: got %0d required 2047", r); end
  endtask

  task automatic test_back_to_back();
    int nd, res;
    do_reset();
    enable = 1'b0; incoming_sample = 12'd321;
    start = 1'b1;
    @(posedge clock); #1;
    incoming_sample = 12'd999;          // second start, must be dropped
    @(posedge clock); #1;
    start = 1'b0;
    nd = 0; res = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (done) begin nd++; res = $signed(modified_sample); end
    end
    vecs++; if (nd !== 1) begin errs++; $display("FAIL busy_ndone: got %0d required 1", nd); end
    vecs++; if (res !== 321) begin errs++; $display("FAIL busy_out: got %0d required 321", res); end
  endtask

  task automatic test_abort();
    int r, l, n, nd;
    do_reset();
    run_sample(1'b1, 3'd3, 3'd7, 500, r, l, n);    // held=500, counter=3
    vecs++; if (r !== 500) begin errs++; $display("FAIL abort_setup: got %0d required 500", r); end
    enable = 1'b1; incoming_sample = 12'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b0;
    nd = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      if (done) nd++;
    end
    vecs++; if (nd !== 0) begin errs++; $display("FAIL abort_ndone: got %0d required 0", nd); end
    vecs++; if (modified_sample !== 12'd0) begin errs++; $display("FAIL abort_out: got %0d required 0", $signed(modified_sample)); end
    reset = 1'b1;
    @(posedge clock); #1;
    run_sample(1'b1, 3'd3, 3'd7, 77, r, l, n);
    vecs++; if (r !== 77 || l !== 3) begin errs++; $display("FAIL abort_refresh: got %0d lat %0d required 77 lat 3", r, l); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_hold();
    test_mix();
    test_floor_extremes();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
